// File: rtl/bus_cycle_controller.sv
// Round-robin bus cycle controller for two requesters sharing a split memory/I/O bus.
// Each granted access holds its region select for 1+wait cycles, then pulses done.
module bus_cycle_controller #(
   parameter int DATA_W   = 8,
   parameter int MEM_WAIT = 1,
   parameter int IO_WAIT  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [15:0]       m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [15:0]       m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m0_done,
   output logic              m1_done,
   output logic [DATA_W-1:0] rdata,
   output logic [15:0]       bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic              bus_we,
   output logic              mem_sel,
   output logic              io_sel,
   input  logic [DATA_W-1:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

   localparam logic [3:0] MEM_WAIT_4 = 4'(MEM_WAIT);
   localparam logic [3:0] IO_WAIT_4  = 4'(IO_WAIT);

   state_t     state;
   logic [3:0] wait_cnt;
   logic       last_grant;
   logic       grant;
   logic       pick_m1;
   logic [3:0] wait_val;
   logic       final_sel;

   always_comb begin
      // With both requesting, the side not served last wins.
      pick_m1   = (m0_req && m1_req) ? ~last_grant : m1_req;
      wait_val  = bus_addr[15] ? IO_WAIT_4 : MEM_WAIT_4;
      final_sel = ((state == ACCESS) && (wait_val == 4'd0)) ||
                  ((state == WAIT) && (wait_cnt == 4'd1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wait_cnt   <= 4'd0;
         last_grant <= 1'b1;
         grant      <= 1'b0;
         mem_sel    <= 1'b0;
         io_sel     <= 1'b0;
         bus_we     <= 1'b0;
         m0_done    <= 1'b0;
         m1_done    <= 1'b0;
         rdata      <= '0;
         bus_addr   <= 16'h0000;
         bus_wdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_req || m1_req) begin
                  grant     <= pick_m1;
                  bus_addr  <= pick_m1 ? m1_addr  : m0_addr;
                  bus_wdata <= pick_m1 ? m1_wdata : m0_wdata;
                  bus_we    <= pick_m1 ? m1_we    : m0_we;
                  mem_sel   <= pick_m1 ? ~m1_addr[15] : ~m0_addr[15];
                  io_sel    <= pick_m1 ?  m1_addr[15] :  m0_addr[15];
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (!final_sel) begin
                  wait_cnt <= wait_val;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
            end
            DONE: begin
               m0_done    <= 1'b0;
               m1_done    <= 1'b0;
               last_grant <= grant;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Last select cycle: drop the bus, capture read data, raise done.
         if (final_sel) begin
            mem_sel <= 1'b0;
            io_sel  <= 1'b0;
            bus_we  <= 1'b0;
            if (!bus_we) rdata <= bus_rdata;
            m0_done <= ~grant;
            m1_done <= grant;
            state   <= DONE;
         end
      end
   end

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Scoreboard bench: drivers push expected transactions, a negedge monitor pops and checks on each done.
// Instance 0 uses MEM_WAIT=1/IO_WAIT=3, instance 1 uses MEM_WAIT=0/IO_WAIT=3.
module tb_bus_cycle_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] bus_rdata = 8'h00;

   logic       m0_req[2], m1_req[2], m0_we[2], m1_we[2];
   logic [15:0] m0_addr[2], m1_addr[2];
   logic [7:0] m0_wdata[2], m1_wdata[2];
   logic       m0_done[2], m1_done[2], mem_sel[2], io_sel[2], bus_we[2];
   logic [7:0] rdata[2], bus_wdata[2];
   logic [15:0] bus_addr[2];

   typedef struct {
      bit          m1;
      bit          io;
      int          len;
      bit          we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  rdata;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   logic [7:0] mrd[2];
   int total = 0;
   int bad = 0;

   int run[2];
   bit r_io[2], r_mem[2], r_we_any[2], r_we_all[2], pd[2];

   always #5 clk = ~clk;

   bus_cycle_controller #(.DATA_W(8), .MEM_WAIT(1), .IO_WAIT(3)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req[0]), .m0_we(m0_we[0]), .m0_addr(m0_addr[0]), .m0_wdata(m0_wdata[0]),
      .m1_req(m1_req[0]), .m1_we(m1_we[0]), .m1_addr(m1_addr[0]), .m1_wdata(m1_wdata[0]),
      .m0_done(m0_done[0]), .m1_done(m1_done[0]), .rdata(rdata[0]),
      .bus_addr(bus_addr[0]), .bus_wdata(bus_wdata[0]), .bus_we(bus_we[0]),
      .mem_sel(mem_sel[0]), .io_sel(io_sel[0]), .bus_rdata(bus_rdata)
   );

   bus_cycle_controller #(.DATA_W(8), .MEM_WAIT(0), .IO_WAIT(3)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req[1]), .m0_we(m0_we[1]), .m0_addr(m0_addr[1]), .m0_wdata(m0_wdata[1]),
      .m1_req(m1_req[1]), .m1_we(m1_we[1]), .m1_addr(m1_addr[1]), .m1_wdata(m1_wdata[1]),
      .m0_done(m0_done[1]), .m1_done(m1_done[1]), .rdata(rdata[1]),
      .bus_addr(bus_addr[1]), .bus_wdata(bus_wdata[1]), .bus_we(bus_we[1]),
      .mem_sel(mem_sel[1]), .io_sel(io_sel[1]), .bus_rdata(bus_rdata)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Monitor: invariants every cycle, full transaction check whenever a done appears.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         exp_t e;
         bit   sel;
         if (!rst_n) begin
            chk("reset_state", {mem_sel[k], io_sel[k], bus_we[k], m0_done[k], m1_done[k],
                                rdata[k], bus_addr[k], bus_wdata[k]}, 64'h0);
            run[k] = 0; r_io[k] = 0; r_mem[k] = 0; r_we_any[k] = 0; r_we_all[k] = 1; pd[k] = 0;
         end else begin
            sel = mem_sel[k] | io_sel[k];
            if (mem_sel[k] && io_sel[k]) chk("sel_onehot", 2'b11, 2'b01);
            if (!sel && bus_we[k]) chk("we_without_sel", bus_we[k], 1'b0);
            if (pd[k] && sel) chk("idle_gap_after_done", sel, 1'b0);
            if (sel) begin
               run[k]++;
               r_io[k]     |= io_sel[k];
               r_mem[k]    |= mem_sel[k];
               r_we_any[k] |= bus_we[k];
               r_we_all[k] &= bus_we[k];
            end
            if (m0_done[k] || m1_done[k]) begin
               if (pd[k]) chk("done_pulse_width", 2, 1);
               if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                  chk("unexpected_done", {m1_done[k], m0_done[k]}, 2'b00);
               end else begin
                  e = (k == 0) ? q0.pop_front() : q1.pop_front();
                  chk("done_id", {m1_done[k], m0_done[k]}, e.m1 ? 2'b10 : 2'b01);
                  chk("sel_len", run[k], e.len);
                  chk("io_sel_used", r_io[k], e.io);
                  chk("mem_sel_used", r_mem[k], !e.io);
                  chk("bus_we_any", r_we_any[k], e.we);
                  chk("bus_we_all", r_we_all[k], e.we);
                  chk("bus_addr", bus_addr[k], e.addr);
                  chk("bus_wdata", bus_wdata[k], e.wdata);
                  chk("rdata", rdata[k], e.rdata);
               end
               run[k] = 0; r_io[k] = 0; r_mem[k] = 0; r_we_any[k] = 0; r_we_all[k] = 1;
            end
            pd[k] = m0_done[k] | m1_done[k];
         end
      end
   end

   task automatic issue(input int k, input bit m, input bit we, input logic [15:0] a,
                        input logic [7:0] wd, input logic [7:0] rd);
      exp_t e;
      int   w;
      w = a[15] ? 3 : ((k == 0) ? 1 : 0);
      e.m1 = m; e.io = a[15]; e.len = 1 + w; e.we = we;
      e.addr = a; e.wdata = wd; e.rdata = we ? mrd[k] : rd;
      if (!we) mrd[k] = rd;
      if (k == 0) q0.push_back(e); else q1.push_back(e);
      bus_rdata = rd;
      if (!m) begin
         m0_we[k] = we; m0_addr[k] = a; m0_wdata[k] = wd; m0_req[k] = 1'b1;
      end else begin
         m1_we[k] = we; m1_addr[k] = a; m1_wdata[k] = wd; m1_req[k] = 1'b1;
      end
   endtask

   task automatic wait_done(input int k, input bit m);
      bit seen;
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if ((m ? m1_done[k] : m0_done[k]) === 1'b1) seen = 1;
      end
      chk("done_seen", seen, 1'b1);
   endtask

   task automatic drop(input int k, input bit m);
      if (!m) m0_req[k] = 1'b0; else m1_req[k] = 1'b0;
   endtask

   initial begin
      int n;
      for (int k = 0; k < 2; k++) begin
         m0_req[k] = 0; m1_req[k] = 0; m0_we[k] = 0; m1_we[k] = 0;
         m0_addr[k] = 0; m1_addr[k] = 0; m0_wdata[k] = 0; m1_wdata[k] = 0;
         mrd[k] = 8'h00; run[k] = 0; pd[k] = 0; r_we_all[k] = 1;
      end
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // Memory read with one wait state.
      issue(0, 0, 0, 16'h1234, 8'h00, 8'hA5);
      wait_done(0, 0); drop(0, 0);
      repeat (2) @(negedge clk);

      // I/O write: rdata must keep 0xA5.
      issue(0, 1, 1, 16'h8000, 8'h3C, 8'hEE);
      wait_done(0, 1); drop(0, 1);
      repeat (2) @(negedge clk);

      // Region boundary, back-to-back on a held request.
      issue(0, 0, 0, 16'h7FFF, 8'h00, 8'h11);
      wait_done(0, 0);
      issue(0, 0, 0, 16'hFFFF, 8'h00, 8'h22);
      wait_done(0, 0); drop(0, 0);
      repeat (2) @(negedge clk);

      // Reset in the second WAIT cycle of an I/O read; the held request is re-run.
      issue(0, 1, 0, 16'h9000, 8'h00, 8'h6B);
      n = 0;
      for (int i = 0; i < 20 && n < 3; i++) begin
         @(negedge clk);
         if (io_sel[0]) n++;
      end
      chk("io_sel_reached_wait2", n, 3);
      #2 rst_n = 1'b0;
      #1 chk("abort_drops_bus", {mem_sel[0], io_sel[0], bus_we[0]}, 3'b000);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      wait_done(0, 1); drop(0, 1);
      repeat (2) @(negedge clk);

      issue(0, 1, 1, 16'h8001, 8'h99, 8'h00);
      wait_done(0, 1); drop(0, 1);
      repeat (2) @(negedge clk);

      // Continuous contention: last grant is m1, so m0, m1, m0, m1.
      issue(0, 0, 0, 16'h0100, 8'h01, 8'h5A);
      issue(0, 1, 0, 16'h8100, 8'h02, 8'h5A);
      issue(0, 0, 0, 16'h0100, 8'h01, 8'h5A);
      issue(0, 1, 0, 16'h8100, 8'h02, 8'h5A);
      wait_done(0, 1);
      wait_done(0, 1);
      drop(0, 0); drop(0, 1);
      repeat (2) @(negedge clk);

      // Zero memory wait states on the second instance.
      issue(1, 0, 0, 16'h0200, 8'h00, 8'h77);
      wait_done(1, 0); drop(1, 0);
      repeat (4) @(negedge clk);

      chk("queue0_drained", q0.size(), 0);
      chk("queue1_drained", q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bus_cycle_controller.md
# bus_cycle_controller

Sequences and arbitrates accesses to the shared 16-bit address/data bus that is split into a memory region (0x0000–0x7FFF) and an I/O region (0x8000–0xFFFF). Two requesters (m0, m1) issue single read/write transactions. The block grants the bus round-robin, registers the winning request, and drives the bus with the correct region select. It holds that select for a region-specific number of wait states, then returns read data with a one-cycle done pulse. It sits between the CPU-side requesters and the memory/I/O devices, replacing the free-running combinational decode with a timed bus cycle.

## Interface
- DATA_W, 8, data bus width
- MEM_WAIT, 1, extra select cycles for memory accesses (0..15)
- IO_WAIT, 3, extra select cycles for I/O accesses (0..15)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  level request, held until matching done
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  16  byte address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_done / m1_done  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read data, valid while either done is high
- bus_addr  out  16  registered bus address
- bus_wdata  out  DATA_W  registered write data
- bus_we  out  1  write strobe, high only while a select is high
- mem_sel  out  1  memory select
- io_sel  out  1  I/O select
- bus_rdata  in  DATA_W  data from the selected device

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE
  - If any req is high, grant one requester and latch its addr, we and wdata. Go to ACCESS.
  - Later changes on requester inputs are ignored until the next grant.
- Arbitration is round-robin on a 1-bit last-grant pointer.
  - If only one requester is requesting, it wins.
  - If both request, the one not granted last wins.
  - The pointer resets to m1, so m0 wins the first contention.
- Region is decided from latched addr[15]:
  - 0 → mem_sel and MEM_WAIT.
  - 1 → io_sel and IO_WAIT.
  - Exactly one select is high in ACCESS/WAIT. Both selects are low in IDLE/DONE.
- ACCESS
  - Drive the select, plus bus_we = latched we.
  - Load the wait counter with the region's wait value.
  - If that value is 0, go to DONE. Otherwise go to WAIT.
- WAIT
  - Select and bus_we stay held.
  - The counter decrements each cycle. Leave WAIT for DONE on the cycle the counter reads 1.
- On the final select cycle (the edge leaving ACCESS or WAIT for DONE), capture bus_rdata into rdata. Capture applies to reads only; rdata is unchanged on writes.
- DONE
  - Pulse the granted requester's done for 1 cycle.
  - Update the last-grant pointer. Return to IDLE.
- A req still high in IDLE after its done counts as a new transaction.
- bus_addr and bus_wdata hold their last values between transactions.

## Timing
- Reset (asynchronous, immediate)
  - State goes to IDLE.
  - mem_sel, io_sel, bus_we, m0_done, m1_done, rdata, bus_addr and bus_wdata go to 0.
  - Last-grant pointer goes to m1.
- Reset during ACCESS/WAIT/DONE aborts the transaction. No done is issued, and a request still high after reset is re-arbitrated.
- Request sampled high in IDLE at edge N:
  - Select is high for cycles N+1 … N+1+W, where W is the region's wait value.
  - done is high in cycle N+2+W.
  - IDLE is cycle N+3+W, where the next grant is sampled.
- Select duration is 1+W cycles. Request-to-done latency is 2+W cycles after grant.
- Minimum spacing between transactions is one idle cycle with both selects low.
- rdata is stable from the done cycle until the next read capture.

## Test plan
- MEM_WAIT=1, m0 reads 0x1234, bus_rdata=0xA5 → mem_sel high exactly 2 cycles, io_sel 0, bus_we 0, m0_done pulses 1 cycle, rdata=0xA5.
- IO_WAIT=3, m1 writes 0x3C to 0x8000 → io_sel and bus_we high 4 cycles, bus_addr=0x8000, bus_wdata=0x3C, m1_done 1 cycle, rdata unchanged.
- Boundary: reads to 0x7FFF then 0xFFFF → the first uses mem_sel (2 cycles), the second uses io_sel (4 cycles), with one idle cycle between them with both selects low.
- m0 and m1 both request continuously → grants m0, m1, m0, m1; no requester is granted twice in a row; dones alternate.
- Assert rst_n=0 in the second WAIT cycle of an I/O access → selects and bus_we drop immediately, no done is issued, and after release the held request is re-granted and completes normally.
- MEM_WAIT=0 → mem_sel high 1 cycle, done in the next cycle.
